// File: rtl/mpram_pkg.sv
// Shared types, latency constants and the saturating-increment helper for the
// mpram responder slice.
package mpram_pkg;

  localparam int RD_DLY_COMB    = 0;
  localparam int RD_DLY_REG     = 1;
  localparam int DATA_WIDTH     = 16;
  localparam int SAT_MAX_WIDTH  = 64;

  typedef struct packed {
    logic                  valid;
    logic                  concrete;
    logic                  oob;
    logic [DATA_WIDTH-1:0] data;
  } rd_resp_t;

  // Counters narrower than SAT_MAX_WIDTH are zero-extended in and truncated out.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
    input logic [SAT_MAX_WIDTH-1:0] value,
    input int                       width
  );
    logic [SAT_MAX_WIDTH-1:0] max_v;
    if (width >= SAT_MAX_WIDTH) begin
      max_v = {SAT_MAX_WIDTH{1'b1}};
    end else begin
      max_v = (64'd1 << width) - 64'd1;
    end
    if (value >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = value + 64'd1;
    end
  endfunction

endpackage

// File: rtl/mpram_sat_counter.sv
// Saturating statistics counter: counts inc pulses, holds at all-ones.
module mpram_sat_counter
  import mpram_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= WIDTH'(sat_inc(SAT_MAX_WIDTH'(count_r), WIDTH));
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mpram_responder.sv
// Memory-side responder tracking written-since-reset state per entry.
// Optional macro MPRAM_RESPONDER_BYPASS_EN: same-cycle write/read to one index forwards wr_data.
module mpram_responder
  import mpram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_DEPTH   = 256,
  parameter int RD_DATA_DLY = RD_DLY_REG,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_concrete,
  output logic                  rd_oob,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int                  IDX_W     = $clog2(MAX_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MAX_DEPTH);

  typedef struct packed {
    logic                  valid;
    logic                  concrete;
    logic                  oob;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  logic [DATA_WIDTH-1:0] mem_r [MAX_DEPTH];
  logic [MAX_DEPTH-1:0]  written_r;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic                  wr_ok_s;
  logic                  rd_oob_s;
  logic                  miss_inc_s;
  resp_t                 lookup_s;
  resp_t                 resp_s;

  assign wr_idx_s = wr_addr[IDX_W-1:0];
  assign rd_idx_s = rd_addr[IDX_W-1:0];

  // Request decode and read lookup; all response fields are zero when idle
  always_comb begin
    wr_ok_s           = wr_en & ({1'b0, wr_addr} < DEPTH_EXT);
    rd_oob_s          = ({1'b0, rd_addr} >= DEPTH_EXT);
    lookup_s          = '0;
    lookup_s.valid    = rd_en;
    lookup_s.oob      = rd_en & rd_oob_s;
`ifdef MPRAM_RESPONDER_BYPASS_EN
    if (rd_en & wr_ok_s & ~rd_oob_s & (wr_idx_s == rd_idx_s)) begin
      lookup_s.concrete = 1'b1;
      lookup_s.data     = wr_data;
    end else begin
      lookup_s.concrete = rd_en & ~rd_oob_s & written_r[rd_idx_s];
      lookup_s.data     = lookup_s.concrete ? mem_r[rd_idx_s] : '0;
    end
`else
    lookup_s.concrete = rd_en & ~rd_oob_s & written_r[rd_idx_s];
    lookup_s.data     = lookup_s.concrete ? mem_r[rd_idx_s] : '0;
`endif
    miss_inc_s        = rd_en & ~lookup_s.concrete;
  end

  // Storage array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_idx_s] <= wr_data;
    end
  end

  // Written-since-reset flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written_r <= '0;
    end else if (wr_ok_s) begin
      written_r[wr_idx_s] <= 1'b1;
    end
  end

  generate
    if (RD_DATA_DLY == RD_DLY_COMB) begin : g_rd_comb
      assign resp_s = lookup_s;
    end else begin : g_rd_reg
      resp_t resp_r;
      // Registered response, one cycle after the request
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          resp_r <= '0;
        end else begin
          resp_r <= lookup_s;
        end
      end
      assign resp_s = resp_r;
    end
  endgenerate

  assign rd_valid    = resp_s.valid;
  assign rd_data     = resp_s.data;
  assign rd_concrete = resp_s.concrete;
  assign rd_oob      = resp_s.oob;

  mpram_sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wr_ok_s),
    .count (wr_count)
  );

  mpram_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc_s),
    .count (miss_count)
  );

endmodule
